// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master serial data path.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned SPI_DATA_W = 8;
  localparam int unsigned SEL_W      = 64;

  // Returns bit idx of a width-bit word counted from the end chosen by lsbfe.
  function automatic logic bit_sel(input logic [SEL_W-1:0] sr,
                                   input int unsigned       idx,
                                   input int unsigned       width,
                                   input logic              lsbfe);
    logic [SEL_W-1:0] sh;
    sh = sr >> (lsbfe ? idx : (width - 1 - idx));
    return sh[0];
  endfunction

endpackage

// File: rtl/spi_strobe_edge.sv
// Rising-edge detector for one baud-generator strobe; clr holds it idle between transfers.
module spi_strobe_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic strb_i,
  output logic edge_o
);

  logic strb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      strb_q <= 1'b0;
    end else begin
      strb_q <= strb_i;
    end
  end

  assign edge_o = strb_i & ~strb_q;

endmodule

// File: rtl/spi_shift_register.sv
// SPI master serial data path: serialises data_mosi onto mosi and assembles miso into data_miso.
module spi_shift_register
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              send_data,
  input  logic [DATA_W-1:0] data_mosi,
  input  logic              lsbfe,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              ss,
  input  logic              flag_low,
  input  logic              flags_low,
  input  logic              flag_high,
  input  logic              flags_high,
  input  logic              miso,
  output logic              mosi,
  output logic [DATA_W-1:0] data_miso,
  output logic              receive_data,
  output logic              busy
);

  localparam int unsigned    CW        = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_W - 1);

  state_e              state_q;
  logic [DATA_W-1:0]   tx_sr_q;
  logic [DATA_W-1:0]   rx_sr_q;
  logic [DATA_W-1:0]   data_miso_q;
  logic [CW-1:0]       tx_cnt_q;
  logic [CW-1:0]       rx_cnt_q;
  logic                lsbfe_q;
  logic                mosi_q;
  logic                busy_q;
  logic                receive_q;

  logic                sel;
  logic                tx_strb;
  logic                rx_strb;
  logic                tx_edge;
  logic                rx_edge;
  logic                edge_clr;
  logic [DATA_W-1:0]   rx_shifted;
  logic                tx_next_bit;

  always_comb begin
    sel         = cpol ^ cpha;
    tx_strb     = sel ? flags_high : flags_low;
    rx_strb     = sel ? flag_high  : flag_low;
    edge_clr    = (state_q == IDLE);
    // LSB-first data arrives lowest bit first, so it enters at the MSB and walks down.
    rx_shifted  = lsbfe_q ? {miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso};
    tx_next_bit = bit_sel(SEL_W'(tx_sr_q), 32'(tx_cnt_q), DATA_W, lsbfe_q);
  end

  spi_strobe_edge u_tx_edge (
    .clk_i  (PCLK),
    .rst_i  (PRESET),
    .clr_i  (edge_clr),
    .strb_i (tx_strb),
    .edge_o (tx_edge)
  );

  spi_strobe_edge u_rx_edge (
    .clk_i  (PCLK),
    .rst_i  (PRESET),
    .clr_i  (edge_clr),
    .strb_i (rx_strb),
    .edge_o (rx_edge)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      data_miso_q <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      lsbfe_q     <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      receive_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          receive_q <= 1'b0;
          if (send_data && !ss) begin
            tx_sr_q  <= data_mosi;
            lsbfe_q  <= lsbfe;
            mosi_q   <= lsbfe ? data_mosi[0] : data_mosi[DATA_W-1];
            tx_cnt_q <= CW'(1);
            rx_cnt_q <= '0;
            rx_sr_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (tx_edge && (tx_cnt_q < CNT_FULL)) begin
              mosi_q   <= tx_next_bit;
              tx_cnt_q <= tx_cnt_q + 1'b1;
            end
            if (rx_edge) begin
              rx_sr_q  <= rx_shifted;
              rx_cnt_q <= rx_cnt_q + 1'b1;
              if (rx_cnt_q == CNT_LAST) begin
                data_miso_q <= rx_shifted;
                receive_q   <= 1'b1;
                state_q     <= DONE;
              end
            end
          end
        end
        DONE: begin
          receive_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          receive_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign mosi         = mosi_q;
  assign data_miso    = data_miso_q;
  assign receive_data = receive_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_spi_shift_register.sv
// Self-checking bench for spi_shift_register: vector table plus abort/reset/ignore sequences.
module tb_spi_shift_register;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       send_data;
  logic [7:0] data_mosi;
  logic       lsbfe;
  logic       cpol;
  logic       cpha;
  logic       ss;
  logic       flag_low;
  logic       flags_low;
  logic       flag_high;
  logic       flags_high;
  logic       miso;
  logic       mosi;
  logic [7:0] data_miso;
  logic       receive_data;
  logic       busy;

  int         tests     = 0;
  int         failed    = 0;
  int         rx_pulses = 0;
  logic       exp_mosi_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] last_rx;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rxb;
    logic       cp;
    logic       ch;
    logic       lsb;
    int         hold;
    bit         mid_send;
  } vec_t;

  vec_t vecs[5];

  always #5 PCLK = ~PCLK;

  spi_shift_register #(.DATA_W(8)) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .send_data    (send_data),
    .data_mosi    (data_mosi),
    .lsbfe        (lsbfe),
    .cpol         (cpol),
    .cpha         (cpha),
    .ss           (ss),
    .flag_low     (flag_low),
    .flags_low    (flags_low),
    .flag_high    (flag_high),
    .flags_high   (flags_high),
    .miso         (miso),
    .mosi         (mosi),
    .data_miso    (data_miso),
    .receive_data (receive_data),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic sample();
    @(negedge PCLK);
  endtask

  // Every receive_data cycle must match the next queued byte.
  always @(negedge PCLK) begin
    if (receive_data) begin
      rx_pulses++;
      if (exp_rx_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_receive_data: got pulse with data_miso %0h, expected no pulse", data_miso);
      end else begin
        chk("data_miso", 32'(data_miso), 32'(exp_rx_q.pop_front()));
      end
    end
  end

  task automatic set_strb(input bit rx, input bit hi, input logic v);
    if (rx) begin
      if (hi) flag_high = v; else flag_low = v;
    end else begin
      if (hi) flags_high = v; else flags_low = v;
    end
  endtask

  // Selected strobe for hold cycles, then a one-cycle decoy on the other pair.
  task automatic pulse(input bit rx, input bit sel, input int hold, input logic bitv);
    if (rx) miso = bitv;
    set_strb(rx, sel, 1'b1);
    repeat (hold) tick();
    set_strb(rx, sel, 1'b0);
    if (rx) miso = ~bitv;
    set_strb(rx, ~sel, 1'b1);
    tick();
    set_strb(rx, ~sel, 1'b0);
    tick();
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] rxb, input logic cp,
                      input logic ch, input logic lsb, input int hold, input bit mid_send,
                      input int ab, input bit ab_rst);
    int         pulses0;
    bit         sel;
    logic [7:0] t;
    sel       = cp ^ ch;
    cpol      = cp;
    cpha      = ch;
    lsbfe     = lsb;
    data_mosi = tx;
    ss        = 1'b0;
    send_data = 1'b1;
    tick();
    send_data = 1'b0;
    data_mosi = ~tx;
    for (int i = 0; i < 8; i++) begin
      t = tx >> (lsb ? i : 7 - i);
      exp_mosi_q.push_back(t[0]);
    end
    if (ab < 0) exp_rx_q.push_back(rxb);
    pulses0 = rx_pulses;
    sample();
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("mosi_bit0", 32'(mosi), 32'(exp_mosi_q.pop_front()));
    for (int i = 0; i < 8; i++) begin
      logic b;
      t = rxb >> (lsb ? i : 7 - i);
      b = t[0];
      if (i == ab) begin
        miso = b;
        set_strb(1'b1, sel, 1'b1);
        if (ab_rst) PRESET = 1'b1; else ss = 1'b1;
        tick();
        set_strb(1'b1, sel, 1'b0);
        PRESET = 1'b0;
        ss     = 1'b0;
        sample();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_receive_data", 32'(receive_data), 32'd0);
        chk("abort_data_miso", 32'(data_miso), ab_rst ? 32'h0 : 32'(last_rx));
        if (ab_rst) begin
          chk("reset_mosi", 32'(mosi), 32'd0);
          last_rx = 8'h00;
        end
        exp_mosi_q.delete();
        tick();
        tick();
        return;
      end
      pulse(1'b1, sel, hold, b);
      if (i < 7) begin
        if (mid_send && i == 3) begin
          data_mosi = 8'h00;
          send_data = 1'b1;
          tick();
          send_data = 1'b0;
        end
        pulse(1'b0, sel, hold, 1'b0);
        sample();
        chk($sformatf("mosi_bit%0d", i + 1), 32'(mosi), 32'(exp_mosi_q.pop_front()));
      end
    end
    sample();
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("receive_pulse_count", 32'(rx_pulses - pulses0), 32'd1);
    last_rx = rxb;
  endtask

  initial begin
    PRESET     = 1'b1;
    send_data  = 1'b0;
    data_mosi  = 8'h00;
    lsbfe      = 1'b0;
    cpol       = 1'b0;
    cpha       = 1'b0;
    ss         = 1'b1;
    flag_low   = 1'b0;
    flags_low  = 1'b0;
    flag_high  = 1'b0;
    flags_high = 1'b0;
    miso       = 1'b0;
    last_rx    = 8'h00;

    vecs[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[1] = '{8'h01, 8'h80, 1'b1, 1'b1, 1'b1, 1, 1'b0};
    vecs[2] = '{8'h6B, 8'hD2, 1'b0, 1'b1, 1'b0, 2, 1'b0};
    vecs[3] = '{8'h3E, 8'h59, 1'b1, 1'b0, 1'b1, 2, 1'b0};
    vecs[4] = '{8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b1};

    tick();
    tick();
    sample();
    chk("reset_mosi", 32'(mosi), 32'd0);
    chk("reset_data_miso", 32'(data_miso), 32'd0);
    chk("reset_receive_data", 32'(receive_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    PRESET = 1'b0;
    ss     = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      xfer(vecs[v].tx, vecs[v].rxb, vecs[v].cp, vecs[v].ch, vecs[v].lsb,
           vecs[v].hold, vecs[v].mid_send, -1, 1'b0);
      tick();
    end

    // send_data with ss high in IDLE must not start a transfer
    ss        = 1'b1;
    data_mosi = 8'h77;
    send_data = 1'b1;
    tick();
    send_data = 1'b0;
    sample();
    chk("ss_high_send_busy", 32'(busy), 32'd0);
    tick();
    sample();
    chk("ss_high_send_busy_later", 32'(busy), 32'd0);
    ss = 1'b0;
    tick();

    // ss abort after 3 rx edges, then abort colliding with the final rx edge
    xfer(8'h96, 8'hF0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 3, 1'b0);
    xfer(8'h5A, 8'hAA, 1'b0, 1'b1, 1'b1, 1, 1'b0, 7, 1'b0);

    // reset mid-transfer, then a normal all-ones transfer
    xfer(8'h81, 8'h18, 1'b1, 1'b1, 1'b0, 1, 1'b0, 2, 1'b1);
    xfer(8'hFF, 8'hE7, 1'b0, 1'b0, 1'b0, 1, 1'b0, -1, 1'b0);
    tick();

    chk("scoreboard_drained", 32'(exp_rx_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
